// File: rtl/alu_seq_pkg.sv
// Shared opcodes, FSM states and default sizing for the sequential ALU.
package alu_seq_pkg;

  localparam int DEFAULT_WIDTH  = 32;
  localparam int DEFAULT_CTRL_W = 4;

  // OP_ILL is the internal code for any Control value outside 1..10.
  typedef enum logic [3:0] {
    OP_ILL  = 4'd0,
    OP_ADD  = 4'd1,
    OP_SUB  = 4'd2,
    OP_MUL  = 4'd3,
    OP_MOD  = 4'd4,
    OP_PASA = 4'd5,
    OP_PASB = 4'd6,
    OP_INCA = 4'd7,
    OP_DECA = 4'd8,
    OP_CLR  = 4'd9,
    OP_DIV  = 4'd10
  } op_e;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_EXEC   = 2'd1,
    S_FINISH = 2'd2
  } state_e;

endpackage

// File: rtl/alu_seq_param_if.sv
// Bus bundle between the register file / control unit and the sequential ALU.
interface alu_seq_param_if
  import alu_seq_pkg::*;
#(
  parameter int WIDTH  = DEFAULT_WIDTH,
  parameter int CTRL_W = DEFAULT_CTRL_W
);
  // A request is taken on a rising edge where enable && ready; Control/A_bus/B_bus
  // are captured on that edge only. done is a one-cycle pulse marking valid results.
  logic              enable;
  logic [CTRL_W-1:0] Control;
  logic [WIDTH-1:0]  A_bus;
  logic [WIDTH-1:0]  B_bus;
  logic              ready;
  logic              done;
  logic [WIDTH-1:0]  C_bus;
  logic [WIDTH-1:0]  C_hi;
  logic              Z_flag;
  logic              C_flag;
  logic              dz_flag;
  logic              ill_flag;
  state_e            dbg_state;
  logic              dbg_div_busy;

  modport master (
    output enable, Control, A_bus, B_bus,
    input  ready, done, C_bus, C_hi, Z_flag, C_flag, dz_flag, ill_flag,
    input  dbg_state, dbg_div_busy
  );

  modport slave (
    input  enable, Control, A_bus, B_bus,
    output ready, done, C_bus, C_hi, Z_flag, C_flag, dz_flag, ill_flag,
    output dbg_state, dbg_div_busy
  );
endinterface

// File: rtl/alu_seq_divider.sv
// Restoring unsigned divider, one quotient bit per clock, MSB first.
module alu_seq_divider #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder
);
  localparam int CNT_W = $clog2(WIDTH);

  logic             busy_q;
  logic [CNT_W-1:0] cnt_q;
  logic [WIDTH-1:0] quo_q;
  logic [WIDTH-1:0] rem_q;
  logic [WIDTH-1:0] div_q;
  logic [WIDTH:0]   shifted;
  logic [WIDTH:0]   trial;

  // quo_q starts as the dividend and is shifted out MSB first as quotient bits shift in.
  assign shifted = {rem_q, quo_q[WIDTH-1]};
  assign trial   = shifted - {1'b0, div_q};

  always_ff @(posedge clk) begin
    if (rst) begin
      busy_q <= 1'b0;
      cnt_q  <= '0;
      quo_q  <= '0;
      rem_q  <= '0;
      div_q  <= '0;
    end else if (start) begin
      busy_q <= 1'b1;
      cnt_q  <= '0;
      quo_q  <= dividend;
      rem_q  <= '0;
      div_q  <= divisor;
    end else if (busy_q) begin
      cnt_q <= cnt_q + 1'b1;
      if (!trial[WIDTH]) begin
        rem_q <= trial[WIDTH-1:0];
        quo_q <= {quo_q[WIDTH-2:0], 1'b1};
      end else begin
        rem_q <= shifted[WIDTH-1:0];
        quo_q <= {quo_q[WIDTH-2:0], 1'b0};
      end
      if (cnt_q == CNT_W'(WIDTH - 1)) busy_q <= 1'b0;
    end
  end

  assign busy      = busy_q;
  assign done      = busy_q && (cnt_q == CNT_W'(WIDTH - 1));
  assign quotient  = quo_q;
  assign remainder = rem_q;
endmodule

// File: rtl/alu_seq_param.sv
// Multi-cycle ALU: single-cycle arithmetic, shift-add MUL, restoring DIV/MOD,
// enable/ready/done handshake and registered result flags.
module alu_seq_param
  import alu_seq_pkg::*;
#(
  parameter int WIDTH  = DEFAULT_WIDTH,
  parameter int CTRL_W = DEFAULT_CTRL_W
) (
  input logic            clk,
  input logic            rst,
  alu_seq_param_if.slave bus
);
  localparam int CNT_W = $clog2(WIDTH);

  state_e             state_q, state_d;
  op_e                op_q, ctrl_op;
  logic [WIDTH-1:0]   a_q, b_q;
  logic [2*WIDTH-1:0] acc_q, mul_next;
  logic [WIDTH:0]     mul_sum;
  logic [CNT_W-1:0]   cnt_q;
  logic               done_q;
  logic [WIDTH-1:0]   c_bus_q, c_hi_q;
  logic               z_q, c_q, dz_q, ill_q;
  logic               accept, iter_op, last_iter;
  logic               div_start, div_busy, div_done;
  logic [WIDTH-1:0]   div_quo, div_rem;
  logic [WIDTH:0]     add_full, sub_full;
  logic [WIDTH-1:0]   res_lo, res_hi;
  logic               res_c, res_dz, res_ill;

  always_comb begin
    ctrl_op = OP_ILL;
    if ((bus.Control >> 4) == '0 && bus.Control[3:0] inside {[4'd1:4'd10]})
      ctrl_op = op_e'(bus.Control[3:0]);
  end

  // ready drops during the done cycle so a request there waits one more clock.
  assign bus.ready = (state_q == S_IDLE) && !done_q;
  assign accept    = bus.enable && bus.ready;
  assign iter_op   = (ctrl_op == OP_MUL) ||
                     ((ctrl_op == OP_DIV || ctrl_op == OP_MOD) && bus.B_bus != '0);
  assign div_start = accept && iter_op && (ctrl_op != OP_MUL);
  assign last_iter = (cnt_q == CNT_W'(WIDTH - 1));

  alu_seq_divider #(.WIDTH(WIDTH)) u_div (
    .clk       (clk),
    .rst       (rst),
    .start     (div_start),
    .dividend  (bus.A_bus),
    .divisor   (bus.B_bus),
    .busy      (div_busy),
    .done      (div_done),
    .quotient  (div_quo),
    .remainder (div_rem)
  );

  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (accept) state_d = iter_op ? S_EXEC : S_FINISH;
      S_EXEC:   if ((op_q == OP_MUL) ? last_iter : div_done) state_d = S_FINISH;
      S_FINISH: state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  // Multiplier lives in acc_q's low half and is consumed LSB first.
  assign mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, a_q} : '0);
  assign mul_next = {mul_sum, acc_q[WIDTH-1:1]};
  assign add_full = {1'b0, a_q} + {1'b0, b_q};
  assign sub_full = {1'b0, a_q} - {1'b0, b_q};

  always_comb begin
    res_lo  = '0;
    res_hi  = '0;
    res_c   = 1'b0;
    res_dz  = 1'b0;
    res_ill = 1'b0;
    case (op_q)
      OP_ADD:  begin res_lo = add_full[WIDTH-1:0]; res_c = add_full[WIDTH]; end
      OP_SUB:  begin res_lo = sub_full[WIDTH-1:0]; res_c = sub_full[WIDTH]; end
      OP_MUL:  begin res_lo = acc_q[WIDTH-1:0]; res_hi = acc_q[2*WIDTH-1:WIDTH]; end
      OP_MOD:  begin res_dz = (b_q == '0); res_lo = res_dz ? a_q : div_rem; end
      OP_DIV:  begin res_dz = (b_q == '0); res_lo = res_dz ? '1 : div_quo; end
      OP_PASA: res_lo = a_q;
      OP_PASB: res_lo = b_q;
      OP_INCA: res_lo = a_q + WIDTH'(1);
      OP_DECA: res_lo = a_q - WIDTH'(1);
      OP_CLR:  res_lo = '0;
      default: begin res_lo = c_bus_q; res_hi = c_hi_q; res_ill = 1'b1; end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      op_q    <= OP_ILL;
      a_q     <= '0;
      b_q     <= '0;
      acc_q   <= '0;
      cnt_q   <= '0;
      done_q  <= 1'b0;
      c_bus_q <= '0;
      c_hi_q  <= '0;
      z_q     <= 1'b0;
      c_q     <= 1'b0;
      dz_q    <= 1'b0;
      ill_q   <= 1'b0;
    end else begin
      done_q <= (state_q == S_FINISH);
      if (accept) begin
        op_q  <= ctrl_op;
        a_q   <= bus.A_bus;
        b_q   <= bus.B_bus;
        acc_q <= {{WIDTH{1'b0}}, bus.B_bus};
        cnt_q <= '0;
      end else if (state_q == S_EXEC) begin
        cnt_q <= cnt_q + 1'b1;
        if (op_q == OP_MUL) acc_q <= mul_next;
      end
      if (state_q == S_FINISH) begin
        c_bus_q <= res_lo;
        c_hi_q  <= res_hi;
        z_q     <= (res_lo == '0);
        c_q     <= res_c;
        dz_q    <= res_dz;
        ill_q   <= res_ill;
      end
    end
  end

  assign bus.done         = done_q;
  assign bus.C_bus        = c_bus_q;
  assign bus.C_hi         = c_hi_q;
  assign bus.Z_flag       = z_q;
  assign bus.C_flag       = c_q;
  assign bus.dz_flag      = dz_q;
  assign bus.ill_flag     = ill_q;
  assign bus.dbg_state    = state_q;
  assign bus.dbg_div_busy = div_busy;
endmodule

// File: tb/tb_alu_seq_param.sv
// Directed scoreboard bench for alu_seq_param at WIDTH=32 and WIDTH=8.
module tb_alu_seq_param;
  import alu_seq_pkg::*;

  typedef struct {
    logic [63:0] lo;
    logic [63:0] hi;
    logic [3:0]  fl;   // {Z, C, dz, ill}
    int          ec;   // edge count at which done must be visible
    string       name;
  } exp_t;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   ec  = 0;
  always #5 clk = ~clk;
  always @(posedge clk) ec <= ec + 1;

  alu_seq_param_if #(.WIDTH(32), .CTRL_W(4)) b32 ();
  alu_seq_param_if #(.WIDTH(8),  .CTRL_W(4)) b8 ();

  alu_seq_param #(.WIDTH(32), .CTRL_W(4)) dut32 (.clk(clk), .rst(rst), .bus(b32));
  alu_seq_param #(.WIDTH(8),  .CTRL_W(4)) dut8  (.clk(clk), .rst(rst), .bus(b8));

  exp_t q32[$];
  exp_t q8[$];
  int   n_cmp = 0;
  int   n_err = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h required %0h", name, act, exp);
    end
  endtask

  task automatic fail_note(input string msg);
    n_cmp++;
    n_err++;
    $display("FAIL %s", msg);
  endtask

  // ---------------- driver tasks ----------------
  task automatic drive(input int w, input logic en, input logic [3:0] op,
                       input logic [63:0] a, input logic [63:0] b);
    if (w == 32) begin
      b32.enable = en; b32.Control = op; b32.A_bus = a[31:0]; b32.B_bus = b[31:0];
    end else begin
      b8.enable = en; b8.Control = op; b8.A_bus = a[7:0]; b8.B_bus = b[7:0];
    end
  endtask

  function automatic logic rdy(input int w);
    return (w == 32) ? b32.ready : b8.ready;
  endfunction

  task automatic push_exp(input int w, input string name, input logic [63:0] lo,
                          input logic [63:0] hi, input logic [3:0] fl, input int lat);
    exp_t e;
    e.lo = lo; e.hi = hi; e.fl = fl; e.ec = ec + 1 + lat; e.name = name;
    if (w == 32) q32.push_back(e);
    else         q8.push_back(e);
  endtask

  // Holds enable for exactly one clock once ready is seen, then scrambles operands.
  task automatic issue(input int w, input string name, input logic [3:0] op,
                       input logic [63:0] a, input logic [63:0] b,
                       input logic [63:0] lo, input logic [63:0] hi,
                       input logic [3:0] fl, input bit iter);
    int k;
    k = 0;
    @(negedge clk);
    while (!rdy(w) && k < 200) begin
      @(negedge clk);
      k++;
    end
    if (!rdy(w)) begin
      fail_note({name, "_ready_timeout: ready stayed 0, required 1"});
      return;
    end
    drive(w, 1'b1, op, a, b);
    push_exp(w, name, lo, hi, fl, iter ? w + 1 : 1);
    @(negedge clk);
    drive(w, 1'b0, 4'hF, {$urandom, $urandom}, {$urandom, $urandom});
  endtask

  task automatic drain();
    int k;
    k = 0;
    while ((q32.size() != 0 || q8.size() != 0) && k < 200) begin
      @(negedge clk);
      k++;
    end
    check("drain_q32", 64'(q32.size()), 64'd0);
    check("drain_q8", 64'(q8.size()), 64'd0);
  endtask

  // ---------------- scoreboard monitor ----------------
  task automatic mon_check(input int w, input logic [63:0] lo, input logic [63:0] hi,
                           input logic [3:0] fl);
    exp_t e;
    if ((w == 32 && q32.size() == 0) || (w == 8 && q8.size() == 0)) begin
      fail_note($sformatf("done%0d_unexpected: got done=1 at edge %0d, required no done", w, ec));
      return;
    end
    if (w == 32) e = q32.pop_front();
    else         e = q8.pop_front();
    check({e.name, "/C_bus"}, lo, e.lo);
    check({e.name, "/C_hi"}, hi, e.hi);
    check({e.name, "/flags_ZCdzill"}, 64'(fl), 64'(e.fl));
    check({e.name, "/done_edge"}, 64'(ec), 64'(e.ec));
  endtask

  always @(negedge clk)
    if (!rst && b32.done)
      mon_check(32, 64'(b32.C_bus), 64'(b32.C_hi),
                {b32.Z_flag, b32.C_flag, b32.dz_flag, b32.ill_flag});

  always @(negedge clk)
    if (!rst && b8.done)
      mon_check(8, 64'(b8.C_bus), 64'(b8.C_hi),
                {b8.Z_flag, b8.C_flag, b8.dz_flag, b8.ill_flag});

  task automatic check_idle32(input string tag);
    check({tag, "/ready"}, 64'(b32.ready), 64'd1);
    check({tag, "/done"}, 64'(b32.done), 64'd0);
    check({tag, "/C_bus"}, 64'(b32.C_bus), 64'd0);
    check({tag, "/C_hi"}, 64'(b32.C_hi), 64'd0);
    check({tag, "/flags"}, 64'({b32.Z_flag, b32.C_flag, b32.dz_flag, b32.ill_flag}), 64'd0);
    check({tag, "/state"}, 64'(b32.dbg_state), 64'(S_IDLE));
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int k;
    drive(32, 1'b0, 4'h0, 64'd0, 64'd0);
    drive(8, 1'b0, 4'h0, 64'd0, 64'd0);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check_idle32("reset32");
    check("reset8/ready", 64'(b8.ready), 64'd1);
    check("reset8/C_bus", 64'(b8.C_bus), 64'd0);
    rst = 1'b0;

    //    w   name            op   A                B             C_bus            C_hi             ZCdi     iter
    issue(32, "add_wrap",     1,  64'hFFFFFFFF,   64'h1,         64'h0,           64'h0,           4'b1100, 0);
    issue(32, "add_small",    1,  64'h1,          64'h2,         64'h3,           64'h0,           4'b0000, 0);
    issue(32, "sub_borrow",   2,  64'h5,          64'h7,         64'hFFFFFFFE,    64'h0,           4'b0100, 0);
    issue(32, "sub_plain",    2,  64'h7,          64'h5,         64'h2,           64'h0,           4'b0000, 0);
    issue(32, "mul_hi_one",   3,  64'h10000,      64'h10000,     64'h0,           64'h1,           4'b1000, 1);
    issue(32, "mul_max",      3,  64'hFFFFFFFF,   64'hFFFFFFFF,  64'h1,           64'hFFFFFFFE,    4'b0000, 1);
    issue(32, "ill_11_hold",  11, 64'h0,          64'h0,         64'h1,           64'hFFFFFFFE,    4'b0001, 0);
    issue(32, "mod_100_7",    4,  64'd100,        64'd7,         64'd2,           64'h0,           4'b0000, 1);
    issue(32, "div_100_7",    10, 64'd100,        64'd7,         64'd14,          64'h0,           4'b0000, 1);
    issue(32, "div_big",      10, 64'hFFFFFFFF,   64'h10,        64'h0FFFFFFF,    64'h0,           4'b0000, 1);
    issue(32, "mod_big",      4,  64'hFFFFFFFF,   64'h10,        64'hF,           64'h0,           4'b0000, 1);
    issue(32, "div_small",    10, 64'd5,          64'd7,         64'd0,           64'h0,           4'b1000, 1);
    issue(32, "mod_small",    4,  64'd5,          64'd7,         64'd5,           64'h0,           4'b0000, 1);
    issue(32, "div_zero",     10, 64'd9,          64'd0,         64'hFFFFFFFF,    64'h0,           4'b0010, 0);
    issue(32, "mod_zero",     4,  64'd9,          64'd0,         64'd9,           64'h0,           4'b0010, 0);
    issue(32, "pass_a",       5,  64'h12345678,   64'h9,         64'h12345678,    64'h0,           4'b0000, 0);
    issue(32, "pass_b",       6,  64'h1,          64'hCAFEBABE,  64'hCAFEBABE,    64'h0,           4'b0000, 0);
    issue(32, "inca_wrap",    7,  64'hFFFFFFFF,   64'h3,         64'h0,           64'h0,           4'b1000, 0);
    issue(32, "deca_wrap",    8,  64'h0,          64'h3,         64'hFFFFFFFF,    64'h0,           4'b0000, 0);
    issue(32, "ill_0_hold",   0,  64'h0,          64'h0,         64'hFFFFFFFF,    64'h0,           4'b0001, 0);
    issue(32, "clr",          9,  64'h5,          64'h6,         64'h0,           64'h0,           4'b1000, 0);
    issue(32, "ill_15_hold",  15, 64'h7,          64'h7,         64'h0,           64'h0,           4'b1001, 0);
    drain();

    // Enable held through a whole MUL: exactly one operation, operands frozen at accept.
    @(negedge clk);
    drive(32, 1'b1, 4'd3, 64'd3, 64'd5);
    push_exp(32, "mul_held", 64'd15, 64'd0, 4'b0000, 33);
    @(negedge clk);
    check("held/ready_busy", 64'(b32.ready), 64'd0);
    k = 0;
    while (!b32.done && k < 100) begin
      b32.A_bus = $urandom;
      b32.B_bus = $urandom;
      @(negedge clk);
      k++;
    end
    if (!b32.done) fail_note("held_done_timeout: done never rose, required a pulse");
    b32.enable = 1'b0;
    repeat (40) @(negedge clk);
    check("held/single_op_idle", 64'(b32.dbg_state), 64'(S_IDLE));

    // Reset in the middle of a MUL: no done, everything back to reset values.
    issue(32, "mul_reset", 3, 64'h10000, 64'h10000, 64'h0, 64'h1, 4'b1000, 1);
    repeat (9) @(negedge clk);
    check("rst_mid/state_exec", 64'(b32.dbg_state), 64'(S_EXEC));
    rst = 1'b1;
    void'(q32.pop_back());
    @(negedge clk);
    rst = 1'b0;
    check_idle32("rst_mid");
    repeat (40) @(negedge clk);

    issue(8, "w8_add_wrap",   1,  64'hFF,  64'h1,   64'h0,  64'h0,  4'b1100, 0);
    issue(8, "w8_mul_hi_one", 3,  64'h10,  64'h10,  64'h0,  64'h1,  4'b1000, 1);
    issue(8, "w8_mul_max",    3,  64'hFF,  64'hFF,  64'h01, 64'hFE, 4'b0000, 1);
    issue(8, "w8_div",        10, 64'd200, 64'd7,   64'd28, 64'h0,  4'b0000, 1);
    issue(8, "w8_mod",        4,  64'd200, 64'd7,   64'd4,  64'h0,  4'b0000, 1);
    issue(8, "w8_sub_borrow", 2,  64'h3,   64'h4,   64'hFF, 64'h0,  4'b0100, 0);
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end
endmodule
